// File: rtl/nios_uproc_jtag_mon_cmd_if.sv
// Word-addressed debug memory port between the monitor
// command engine (master) and the debug memory (slave).
//   master: drives address/read/write/writedata/byteenable
//   slave : returns readdata and waitrequest
interface nios_uproc_jtag_mon_cmd_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic [3:0]        mem_byteenable;
  logic [31:0]       mem_readdata;
  logic              mem_waitrequest;

  modport master (
    output mem_address,
    output mem_read,
    output mem_write,
    output mem_writedata,
    output mem_byteenable,
    input  mem_readdata,
    input  mem_waitrequest
  );

  modport slave (
    input  mem_address,
    input  mem_read,
    input  mem_write,
    input  mem_writedata,
    input  mem_byteenable,
    output mem_readdata,
    output mem_waitrequest
  );
endinterface

// File: rtl/nios_uproc_jtag_mon_cmd.sv
// Debug-monitor command engine: decodes JTAG wrapper strobes
// into single-word debug memory reads/writes.
//   clk, reset      : clock, async active-high reset
//   jdo, take_*     : command word and one-cycle strobes
//   mem (master)    : debug memory port
//   MonDReg         : last read data
//   monitor_ready/error : command done / aborted or collided
module nios_uproc_jtag_mon_cmd #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic        take_no_action_ocimem_a,
  nios_uproc_jtag_mon_cmd_if.master mem,
  output logic [31:0] MonDReg,
  output logic        monitor_ready,
  output logic        monitor_error
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE
  } state_e;

  state_e            r_state;
  state_e            w_state_d;
  logic [ADDR_W-1:0] r_areg;
  logic [31:0]       r_mondreg;
  logic [31:0]       r_wdata;
  logic [3:0]        r_be;
  logic [CW-1:0]     r_cnt;
  logic              r_ready;
  logic              r_error;

  logic w_idle;
  logic w_busy;
  logic w_any_strobe;
  logic w_acc_b;
  logic w_acc_a;
  logic w_acc_n;
  logic w_load;
  logic w_ld_only;
  logic w_rd_go;
  logic w_accept;
  logic w_done;
  logic w_tmo;
  logic w_coll;

  assign w_idle       = (r_state == ST_IDLE);
  assign w_busy       = !w_idle;
  assign w_any_strobe = take_action_ocimem_a
                      | take_action_ocimem_b
                      | take_no_action_ocimem_a;

  // b > a > no_action; losers are dropped.
  assign w_acc_b   = w_idle & take_action_ocimem_b;
  assign w_acc_a   = w_idle & !take_action_ocimem_b
                   & take_action_ocimem_a;
  assign w_acc_n   = w_idle & !take_action_ocimem_b
                   & !take_action_ocimem_a
                   & take_no_action_ocimem_a;
  assign w_load    = w_acc_a & jdo[35];
  assign w_ld_only = w_load & !jdo[34];
  assign w_rd_go   = (w_acc_a & !w_ld_only) | w_acc_n;
  assign w_accept  = w_acc_b | w_acc_a | w_acc_n;

  assign w_done = w_busy & !mem.mem_waitrequest;
  assign w_tmo  = w_busy & mem.mem_waitrequest
                & (r_cnt == TMO_LAST);
  assign w_coll = w_busy & w_any_strobe;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_acc_b)      w_state_d = ST_WRITE;
        else if (w_rd_go) w_state_d = ST_READ;
      end
      ST_READ,
      ST_WRITE: begin
        if (w_done || w_tmo) w_state_d = ST_IDLE;
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_areg    <= '0;
      r_mondreg <= '0;
      r_wdata   <= '0;
      r_be      <= 4'hF;
      r_cnt     <= '0;
      r_ready   <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_ready <= 1'b0;
        r_error <= 1'b0;
        r_cnt   <= '0;
      end
      if (w_acc_b) begin
        r_wdata <= jdo[31:0];
        r_be    <= jdo[35:32];
      end
      if (w_rd_go) r_be <= 4'hF;
      if (w_load) r_areg <= jdo[ADDR_W+1:2];
      if (w_ld_only) r_ready <= 1'b1;
      if (w_done) begin
        r_areg  <= r_areg + ADDR_W'(1);
        r_ready <= 1'b1;
        if (r_state == ST_READ)
          r_mondreg <= mem.mem_readdata;
      end
      // Abort leaves AReg and MonDReg untouched.
      if (w_tmo) begin
        r_ready <= 1'b1;
        r_error <= 1'b1;
      end else if (w_busy && mem.mem_waitrequest) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_coll) r_error <= 1'b1;
    end
  end

  assign mem.mem_address    = r_areg;
  assign mem.mem_read       = (r_state == ST_READ);
  assign mem.mem_write      = (r_state == ST_WRITE);
  assign mem.mem_writedata  = r_wdata;
  assign mem.mem_byteenable = r_be;
  assign MonDReg            = r_mondreg;
  assign monitor_ready      = r_ready;
  assign monitor_error      = r_error;

endmodule

// File: tb/tb_nios_uproc_jtag_mon_cmd.sv
// Directed bench for the debug-monitor command engine
// (ADDR_W=8, TIMEOUT=4).
module tb_nios_uproc_jtag_mon_cmd;

  logic        clk;
  logic        reset;
  logic [37:0] jdo;
  logic        sa;
  logic        sb;
  logic        sn;
  logic [31:0] mondreg;
  logic        rdy;
  logic        err;

  int n_chk  = 0;
  int n_pass = 0;
  int cnt;

  nios_uproc_jtag_mon_cmd_if #(.ADDR_W(8)) m ();

  nios_uproc_jtag_mon_cmd #(
    .ADDR_W (8),
    .TIMEOUT(4)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .jdo                    (jdo),
    .take_action_ocimem_a   (sa),
    .take_action_ocimem_b   (sb),
    .take_no_action_ocimem_a(sn),
    .mem                    (m.master),
    .MonDReg                (mondreg),
    .monitor_ready          (rdy),
    .monitor_error          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one strobe cycle; returns 1ns after the sampling edge.
  task automatic strobe(input logic a, input logic b,
                        input logic n, input logic [37:0] d);
    jdo = d;
    sa  = a;
    sb  = b;
    sn  = n;
    step();
    sa  = 1'b0;
    sb  = 1'b0;
    sn  = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd"},  m.mem_read, 1'b0);
    chk({tag, "_wr"},  m.mem_write, 1'b0);
    chk({tag, "_adr"}, m.mem_address, 8'd0);
    chk({tag, "_wd"},  m.mem_writedata, 32'd0);
    chk({tag, "_be"},  m.mem_byteenable, 4'hF);
    chk({tag, "_mon"}, mondreg, 32'd0);
    chk({tag, "_rdy"}, rdy, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
  endtask

  logic [31:0] rd_vals [3];
  logic [7:0]  rd_adrs [3];

  initial begin
    reset = 1'b1;
    jdo   = '0;
    sa    = 1'b0;
    sb    = 1'b0;
    sn    = 1'b0;
    m.mem_readdata   = '0;
    m.mem_waitrequest = 1'b0;
    step();
    step();
    chk_reset_vals("rst");
    reset = 1'b0;
    step();

    // Address-only load of 5, then one zero-wait write.
    strobe(1, 0, 0, {2'b0, 4'h8, 32'h0000_0014});
    chk("ld5_rdy", rdy, 1'b1);
    chk("ld5_rd",  m.mem_read, 1'b0);
    chk("ld5_wr",  m.mem_write, 1'b0);
    chk("ld5_adr", m.mem_address, 8'd5);
    strobe(0, 1, 0, {2'b0, 4'hF, 32'hDEADBEEF});
    chk("wr_wr",  m.mem_write, 1'b1);
    chk("wr_adr", m.mem_address, 8'd5);
    chk("wr_wd",  m.mem_writedata, 32'hDEADBEEF);
    chk("wr_be",  m.mem_byteenable, 4'hF);
    chk("wr_rdy0", rdy, 1'b0);
    step();
    chk("wr_done", m.mem_write, 1'b0);
    chk("wr_rdy", rdy, 1'b1);
    chk("wr_adr6", m.mem_address, 8'd6);
    chk("wr_err", err, 1'b0);

    // Streaming reads across the address wrap.
    strobe(1, 0, 0, {2'b0, 4'h8, 32'h0000_03F8});
    chk("ld254", m.mem_address, 8'd254);
    rd_vals = '{32'h11, 32'h22, 32'h33};
    rd_adrs = '{8'd254, 8'd255, 8'd0};
    for (int i = 0; i < 3; i++) begin
      m.mem_readdata = rd_vals[i];
      strobe(0, 0, 1, '0);
      chk($sformatf("str%0d_rd", i), m.mem_read, 1'b1);
      chk($sformatf("str%0d_adr", i),
          m.mem_address, rd_adrs[i]);
      chk($sformatf("str%0d_be", i), m.mem_byteenable, 4'hF);
      step();
      chk($sformatf("str%0d_mon", i), mondreg, rd_vals[i]);
      chk($sformatf("str%0d_rdy", i), rdy, 1'b1);
      chk($sformatf("str%0d_rdx", i), m.mem_read, 1'b0);
    end
    chk("str_adr1", m.mem_address, 8'd1);

    // Read with three wait cycles at address 1.
    m.mem_waitrequest = 1'b1;
    m.mem_readdata    = 32'hCAFE0001;
    strobe(1, 0, 0, '0);
    cnt = 0;
    while (m.mem_read && cnt < 20) begin
      cnt++;
      if (cnt == 4) m.mem_waitrequest = 1'b0;
      if (cnt < 4) chk("ws_rdy0", rdy, 1'b0);
      step();
    end
    chk("ws_cycles", cnt, 4);
    chk("ws_mon", mondreg, 32'hCAFE0001);
    chk("ws_rdy", rdy, 1'b1);
    chk("ws_adr", m.mem_address, 8'd2);
    chk("ws_err", err, 1'b0);

    // Timeout with waitrequest stuck high.
    m.mem_waitrequest = 1'b1;
    m.mem_readdata    = 32'h99;
    strobe(0, 0, 1, '0);
    cnt = 0;
    while (m.mem_read && cnt < 20) begin
      cnt++;
      step();
    end
    chk("to_cycles", cnt, 4);
    chk("to_err", err, 1'b1);
    chk("to_rdy", rdy, 1'b1);
    chk("to_adr", m.mem_address, 8'd2);
    chk("to_mon", mondreg, 32'hCAFE0001);
    m.mem_waitrequest = 1'b0;
    m.mem_readdata    = 32'h55;
    strobe(0, 0, 1, '0);
    chk("to_clr_err", err, 1'b0);
    chk("to_clr_rd", m.mem_read, 1'b1);
    step();
    chk("to_nx_mon", mondreg, 32'h55);
    chk("to_nx_adr", m.mem_address, 8'd3);

    // Write beats no_action in the same cycle.
    strobe(0, 1, 1, {2'b0, 4'h3, 32'h12345678});
    chk("pr_wr", m.mem_write, 1'b1);
    chk("pr_rd", m.mem_read, 1'b0);
    chk("pr_be", m.mem_byteenable, 4'h3);
    step();
    chk("pr_rdy", rdy, 1'b1);
    chk("pr_err", err, 1'b0);
    chk("pr_adr", m.mem_address, 8'd4);
    chk("pr_mon", mondreg, 32'h55);

    // Strobe during a stalled read.
    m.mem_waitrequest = 1'b1;
    m.mem_readdata    = 32'h77;
    strobe(0, 0, 1, '0);
    step();
    strobe(0, 1, 0, {2'b0, 4'hF, 32'hFFFF0000});
    chk("co_rd", m.mem_read, 1'b1);
    chk("co_wr", m.mem_write, 1'b0);
    chk("co_wd", m.mem_writedata, 32'h12345678);
    m.mem_waitrequest = 1'b0;
    step();
    chk("co_mon", mondreg, 32'h77);
    chk("co_rdy", rdy, 1'b1);
    chk("co_err", err, 1'b1);
    chk("co_adr", m.mem_address, 8'd5);

    // Reset asserted mid-write.
    m.mem_waitrequest = 1'b1;
    strobe(0, 1, 0, {2'b0, 4'h5, 32'hA5A5A5A5});
    chk("rm_wr", m.mem_write, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("rm");
    step();
    reset = 1'b0;
    m.mem_waitrequest = 1'b0;
    m.mem_readdata    = 32'h3C;
    step();
    strobe(0, 0, 1, '0);
    chk("rm_rd", m.mem_read, 1'b1);
    chk("rm_adr", m.mem_address, 8'd0);
    step();
    chk("rm_mon", mondreg, 32'h3C);
    chk("rm_rdy", rdy, 1'b1);
    chk("rm_adr1", m.mem_address, 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
